tl_master: RTL and testbench
============================

TL_MASTER -- requirements
Module: tl_master

Interface
REQ-001 Parameter: a_channel_size, 55, A-channel bus width.
REQ-002 Parameter: d_channel_size, 47, D-channel bus width.
REQ-003 Parameter: TIMEOUT_CYCLES, 64, response wait limit (used only when TL_MASTER_TIMEOUT_EN defined).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = store (Put), 0 = load (Get).
REQ-009 req_addr  input  10  word address.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  load data.
REQ-013 resp_err  output  1  response error flag.
REQ-014 a_channel  output  a_channel_size  A-channel bundle.
REQ-015 a_valid  output  1  A-channel request strobe.
REQ-016 d_channel  input  d_channel_size  D-channel bundle.

Function
REQ-017 A fields SHALL be: opcode[54:52] (4 Get, 0 PutFullData), param[51:49]=0, size[48:46]=5, source[45:44]=0, address[43:34], data[33:2] (0 for Get), valid[1]=a_valid, ready[0]=1.
REQ-018 D fields SHALL be decoded as: opcode[46:44], param[43:42], size[41:37], source[36:35], error[34], data[33:2], valid[1], ready[0].
REQ-019 d_channel[1] SHALL pass a 2-flop synchronizer; d_vs denotes its output; other D fields sampled only when d_vs=1.
REQ-020 FSM states: IDLE, REQ, WAIT_RSP, WAIT_CLR.
REQ-021 IDLE: req_ready=1; req_valid=1 registers opcode/address/data into a_channel, goes to REQ.
REQ-022 REQ: a_valid=1 for the cycle after acceptance, then WAIT_RSP; a_valid held 1 throughout WAIT_RSP.
REQ-023 WAIT_RSP: when d_vs=1, capture data, pulse resp_valid next edge, drop a_valid, go to WAIT_CLR.
REQ-024 resp_err SHALL be 1 if d error=1 or D opcode differs from expected (1 AccessAckData for Get, 0 AccessAck for Put); else 0.
REQ-025 resp_rdata SHALL be D data for Get, 0 for Put.
REQ-026 WAIT_CLR: a_valid=0; return to IDLE when d_vs=0.
REQ-027 req_ready SHALL be 0 in every state except IDLE; req_valid outside IDLE ignored.
REQ-028 d_vs=1 on entering WAIT_RSP from a stale response SHALL NOT occur because WAIT_CLR precedes IDLE.
REQ-029 Minimum turnaround: acceptance to resp_valid = 1 + responder delay + 2 synchronizer cycles + 1.

Reset
REQ-030 reset=0 SHALL immediately force state IDLE, a_channel=0, a_valid=0, resp_valid=0, resp_rdata=0, resp_err=0, synchronizer flops 0; req_ready=1 after release.
REQ-031 Reset mid-transaction SHALL abandon it with no resp_valid.

Configuration
REQ-032 With TL_MASTER_TIMEOUT_EN defined: counter clears on WAIT_RSP entry, increments each WAIT_RSP cycle; reaching TIMEOUT_CYCLES SHALL pulse resp_valid with resp_err=1, resp_rdata=0, drop a_valid, enter WAIT_CLR.
REQ-033 Without TL_MASTER_TIMEOUT_EN: no counter; WAIT_RSP waits indefinitely.

Verification
REQ-034 Store addr 5 data 20, responder acks opcode 0 -> a_channel[54:52]=0, [43:34]=5, [33:2]=20; one resp_valid, resp_err=0.
REQ-035 Load addr 5 after REQ-034, responder returns AccessAckData data 20 -> resp_rdata=20, resp_err=0.
REQ-036 Load with responder d_error=1 -> resp_valid, resp_err=1.
REQ-037 req_valid held high through transaction -> exactly one A request; next accepted only after d_valid drops.
REQ-038 reset=0 in WAIT_RSP -> a_valid=0 same time, no resp_valid, req_ready=1 after release.
REQ-039 TL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> resp_valid with resp_err=1, resp_rdata=0 eight cycles after WAIT_RSP entry.

Source files
------------

// File: rtl/tl_master.sv
// rtl/tl_master.sv - single-outstanding TileLink-style master bridging a CPU request port to A/D channel bundles
// Optional feature: define TL_MASTER_TIMEOUT_EN to abandon a response wait after TIMEOUT_CYCLES.
module tl_master #(
  parameter int a_channel_size = 55,
  parameter int d_channel_size = 47,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [9:0]                req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [a_channel_size-1:0] a_channel,
  output logic                      a_valid,
  input  logic [d_channel_size-1:0] d_channel
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;
  localparam logic [2:0] SIZE_WORD   = 3'd5;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_is_get;
  logic [2:0]  r_a_op;
  logic [2:0]  r_a_size;
  logic [9:0]  r_a_addr;
  logic [31:0] r_a_data;
  logic        r_a_valid;
  logic        r_a_rdy;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_d_sync1;
  logic        r_d_sync2;

  logic        w_d_vs;
  logic [2:0]  w_d_op;
  logic        w_d_err;
  logic [31:0] w_d_data;
  logic [2:0]  w_exp_op;
  logic [54:0] w_a_bundle;
  logic        w_unused_d;

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // D-channel decode; only the valid bit crosses the synchronizer, the rest is
  // trusted to be stable by the time the synchronized valid is seen.
  assign w_d_vs     = r_d_sync2;
  assign w_d_op     = d_channel[46:44];
  assign w_d_err    = d_channel[34];
  assign w_d_data   = d_channel[33:2];
  assign w_unused_d = ^d_channel;
  assign w_exp_op   = r_is_get ? OP_ACK_DATA : OP_ACK;

  // A-channel bundle: opcode, param, size, source, address, data, valid, ready
  assign w_a_bundle = {r_a_op, 3'd0, r_a_size, 2'd0, r_a_addr, r_a_data, r_a_valid, r_a_rdy};
  assign a_channel  = a_channel_size'(w_a_bundle);
  assign a_valid    = r_a_valid;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // Two-flop synchronizer for the responder's valid strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_sync1 <= 1'b0;
      r_d_sync2 <= 1'b0;
    end else begin
      r_d_sync1 <= d_channel[1];
      r_d_sync2 <= r_d_sync1;
    end
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_is_get     <= 1'b0;
      r_a_op       <= 3'd0;
      r_a_size     <= 3'd0;
      r_a_addr     <= 10'd0;
      r_a_data     <= 32'd0;
      r_a_valid    <= 1'b0;
      r_a_rdy      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      r_a_rdy      <= 1'b1;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a_op      <= req_we ? OP_PUT_FULL : OP_GET;
            r_a_size    <= SIZE_WORD;
            r_a_addr    <= req_addr;
            r_a_data    <= req_we ? req_wdata : 32'd0;
            r_is_get    <= ~req_we;
            r_a_valid   <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= REQ;
          end
        end
        REQ: begin
`ifdef TL_MASTER_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          r_state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (w_d_vs) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_is_get ? w_d_data : 32'd0;
            r_resp_err   <= w_d_err | (w_d_op != w_exp_op);
            r_a_valid    <= 1'b0;
            r_state      <= WAIT_CLR;
          end
`ifdef TL_MASTER_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b1;
            r_a_valid    <= 1'b0;
            r_state      <= WAIT_CLR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        WAIT_CLR: begin
          // Hold off new requests until the old response is fully withdrawn
          if (!w_d_vs) begin
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
          r_a_valid   <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_master.sv
// tb/tb_tl_master.sv - directed bench with responder and scoreboard model for tl_master
module tb_tl_master;

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [54:0] a_channel;
  logic        a_valid;
  logic [46:0] d_channel;

  always #5 clk = ~clk;

  tl_master #(.a_channel_size(55), .d_channel_size(47), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .a_channel(a_channel), .a_valid(a_valid), .d_channel(d_channel)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        expq[$];
  exp_t        m_e;
  exp_t        c_e;
  logic [31:0] model_mem [1024];
  logic [31:0] rsp_mem [1024];
  logic [54:0] exp_a = '0;
  int          a_req_cnt = 0;
  int          resp_cnt = 0;
  logic        prev_a_valid = 1'b0;

  bit rsp_en = 1'b1;
  int rsp_delay = 0;
  int rsp_hold = 1;
  bit inj_err = 1'b0;
  bit inj_op = 1'b0;

  // Model: predicts the response of every accepted request from the request itself
  initial begin
    forever begin
      @(posedge clk);
      if (reset && req_valid && req_ready) begin
        exp_a = {(req_we ? 3'd0 : 3'd4), 3'd0, 3'd5, 2'd0, req_addr,
                 (req_we ? req_wdata : 32'd0), 1'b1, 1'b1};
        if (!rsp_en) begin
          m_e.rdata = 32'd0;
          m_e.err   = 1'b1;
        end else begin
          if (req_we) begin
            model_mem[req_addr] = req_wdata;
            m_e.rdata = 32'd0;
          end else begin
            m_e.rdata = model_mem[req_addr];
          end
          m_e.err = inj_err | inj_op;
        end
        expq.push_back(m_e);
      end
    end
  end

  // Compare process: checks outputs on every cycle they carry meaning
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (a_valid && !prev_a_valid) a_req_cnt++;
        prev_a_valid = a_valid;
        if (resp_valid) begin
          resp_cnt++;
          if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
          end else begin
            c_e = expq.pop_front();
            chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, c_e.rdata});
            chk("resp_err", {63'd0, resp_err}, {63'd0, c_e.err});
          end
        end
        if (a_valid) chk("a_channel", {9'd0, a_channel}, {9'd0, exp_a});
        if (req_ready) begin
          chk("ready_a_valid", {63'd0, a_valid}, 64'd0);
          chk("ready_d_valid", {63'd0, d_channel[1]}, 64'd0);
        end
      end else begin
        prev_a_valid = 1'b0;
      end
    end
  end

  // Responder: answers each A request after rsp_delay cycles, withdraws after a_valid drops
  logic [2:0]  t_op;
  logic [9:0]  t_addr;
  logic [31:0] t_data;
  logic [46:0] t_d;
  initial begin
    d_channel = '0;
    forever begin
      @(posedge clk);
      if (reset && a_valid && rsp_en && !d_channel[1]) begin
        t_op   = a_channel[54:52];
        t_addr = a_channel[43:34];
        t_data = a_channel[33:2];
        repeat (rsp_delay) @(posedge clk);
        t_d = '0;
        t_d[46:44] = ((t_op == 3'd0) ? 3'd0 : 3'd1) ^ {2'b00, inj_op};
        t_d[41:37] = 5'd5;
        t_d[34]    = inj_err;
        t_d[33:2]  = (t_op == 3'd0) ? 32'hDEADBEEF : rsp_mem[t_addr];
        t_d[1]     = 1'b1;
        t_d[0]     = 1'b1;
        if (t_op == 3'd0) rsp_mem[t_addr] = t_data;
        #1 d_channel = t_d;
        for (int k = 0; k < 300 && a_valid; k++) @(posedge clk);
        repeat (rsp_hold) @(posedge clk);
        #1 d_channel = '0;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_ready_timeout: got req_ready=0 expected 1 within 300 cycles");
  endtask

  task automatic txn(input bit we, input logic [9:0] addr, input logic [31:0] wdata,
                     input int dly, input int exp_lat,
                     input logic [31:0] lit_rd, input bit lit_err);
    int n;
    bit got;
    rsp_delay = dly;
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("a_op", {61'd0, a_channel[54:52]}, we ? 64'd0 : 64'd4);
    chk("a_addr", {54'd0, a_channel[43:34]}, {54'd0, addr});
    chk("a_data", {32'd0, a_channel[33:2]}, we ? {32'd0, wdata} : 64'd0);
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("latency", got ? 64'(n) : 64'd0, 64'(exp_lat));
    chk("lit_rdata", {32'd0, resp_rdata}, {32'd0, lit_rd});
    chk("lit_err", {63'd0, resp_err}, {63'd0, lit_err});
    wait_ready();
  endtask

  int a0;
  int r0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = 32'd0;
      rsp_mem[i]   = 32'd0;
    end
    #1;
    chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_a_channel", {9'd0, a_channel}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {63'd0, req_ready}, 64'd1);

    // store then load of the same word, then error cases and address/data extremes
    txn(1'b1, 10'd5, 32'd20, 0, 4, 32'd0, 1'b0);
    txn(1'b0, 10'd5, 32'd0, 0, 4, 32'd20, 1'b0);
    inj_err = 1'b1;
    txn(1'b0, 10'd5, 32'd0, 2, 6, 32'd20, 1'b1);
    inj_err = 1'b0;
    txn(1'b1, 10'd1023, 32'hFFFFFFFF, 3, 7, 32'd0, 1'b0);
    txn(1'b0, 10'd1023, 32'd0, 1, 5, 32'hFFFFFFFF, 1'b0);
    inj_op = 1'b1;
    txn(1'b1, 10'd0, 32'hA5A5A5A5, 0, 4, 32'd0, 1'b1);
    txn(1'b0, 10'd0, 32'd0, 0, 4, 32'hA5A5A5A5, 1'b1);
    inj_op = 1'b0;

    // request held high: each transaction must be accepted exactly once
    rsp_delay = 1;
    rsp_hold  = 3;
    wait_ready();
    a0 = a_req_cnt;
    r0 = resp_cnt;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'd7;
    req_wdata = 32'd77;
    for (int i = 0; i < 300 && (resp_cnt - r0) < 2; i++) @(negedge clk);
    req_valid = 1'b0;
    chk("hold_resp_count", 64'(resp_cnt - r0), 64'd2);
    wait_ready();
    chk("hold_a_requests", 64'(a_req_cnt - a0), 64'd2);
    rsp_hold = 1;

    // reset while waiting for a response
    rsp_en = 1'b0;
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_a_valid", {63'd0, a_valid}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_a_valid", {63'd0, a_valid}, 64'd0);
    chk("mid_rst_a_channel", {9'd0, a_channel}, 64'd0);
    chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    expq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rsp_en = 1'b1;
    r0 = resp_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_no_resp", 64'(resp_cnt - r0), 64'd0);

`ifdef TL_MASTER_TIMEOUT_EN
    // no responder: timeout fires eight cycles after entering the wait
    rsp_en = 1'b0;
    txn(1'b0, 10'd9, 32'd0, 0, 1 + TMO, 32'd0, 1'b1);
    rsp_en = 1'b1;
`endif

    txn(1'b0, 10'd7, 32'd0, 0, 4, 32'd77, 1'b0);
    repeat (5) @(negedge clk);
    chk("expq_empty", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
